// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver: one shared hex decoder, slot prescaler,
// and a shadow/active value pair that only swaps at frame boundaries so frames never tear.
module seg_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 100000,
  parameter int BLANK_CYCLES   = 0,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   value_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_lz_in,
  input  logic                      load,
  output logic                      pending,
  output logic                      frame_done,
  output logic [7:0]                seg_out,
  output logic [NUM_DIGITS-1:0]     dig_out
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [7:0]            SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    blank_lz;
  } disp_t;

  logic [PW-1:0]         pcnt;
  logic [IW-1:0]         idx;
  logic                  tick, wrap, blank_slot, lz_blank;
  int                    pcnt_i;
  disp_t                 shadow, active, incoming;
  logic [3:0]            nib;
  logic [NUM_DIGITS-1:0] zero_above;
  logic [7:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] dig_nxt;

  function automatic logic [7:0] hex_code(input logic [3:0] h);
    case (h)
      4'h0: hex_code = 8'hFC;  4'h1: hex_code = 8'h60;
      4'h2: hex_code = 8'hDA;  4'h3: hex_code = 8'hF2;
      4'h4: hex_code = 8'h66;  4'h5: hex_code = 8'hB6;
      4'h6: hex_code = 8'hBE;  4'h7: hex_code = 8'hE0;
      4'h8: hex_code = 8'hFE;  4'h9: hex_code = 8'hE6;
      4'hA: hex_code = 8'hEE;  4'hB: hex_code = 8'h3E;
      4'hC: hex_code = 8'h9C;  4'hD: hex_code = 8'h7A;
      4'hE: hex_code = 8'h9E;  default: hex_code = 8'h8E;
    endcase
  endfunction

  assign incoming   = {value_in, dp_in, blank_lz_in};
  assign tick       = (pcnt == PW'(CLK_DIV - 1));
  assign wrap       = tick && (idx == IW'(NUM_DIGITS - 1));
  assign pcnt_i     = int'(pcnt);
  assign blank_slot = (pcnt_i < BLANK_CYCLES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (tick) begin
      pcnt <= '0;
      idx  <= wrap ? '0 : idx + IW'(1);
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // A load landing on the wrap cycle bypasses the shadow so it shows in the very next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (load) shadow <= incoming;
      if (wrap) begin
        active  <= load ? incoming : (pending ? shadow : active);
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // zero_above[i]: nibbles i..NUM_DIGITS-1 of the active value are all zero.
  always_comb begin
    logic z;
    z          = 1'b1;
    zero_above = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z             = z & (active.value[4*i +: 4] == 4'h0);
      zero_above[i] = z;
    end
  end

  assign nib      = active.value[4*idx +: 4];
  assign lz_blank = active.blank_lz && (idx != '0) && zero_above[idx];

  always_comb begin
    seg_nxt = 8'h00;
    dig_nxt = '0;
    if (!blank_slot) begin
      dig_nxt[idx] = 1'b1;
      seg_nxt      = lz_blank ? 8'h00 : hex_code(nib);
      seg_nxt[0]   = active.dp[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out <= SEG_OFF;
      dig_out <= DIG_OFF;
    end else begin
      seg_out <= seg_nxt ^ SEG_OFF;
      dig_out <= dig_nxt ^ DIG_OFF;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame-level reference model predicts every
// cycle's outputs from the load history; a negedge monitor pops and compares.
module tb_seg_scan_driver;
  localparam int N  = 4;
  localparam int CD = 4;
  localparam int BL = 1;
  localparam int FL = N * CD;
  localparam bit SAL = 1'b0;
  localparam bit DAL = 1'b1;
  localparam logic [7:0] SEG_TAB [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                         8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  value_in = '0;
  logic [3:0]   dp_in = '0;
  logic         blank_lz_in = 1'b0;
  logic         load = 1'b0;
  logic         pending, frame_done;
  logic [7:0]   seg_out;
  logic [3:0]   dig_out;

  typedef struct {int t; logic [15:0] v; logic [3:0] dp; logic blz;} ld_t;
  typedef struct {logic [7:0] seg; logic [3:0] dig; logic pend; logic fd;} exp_t;
  ld_t  loads[$];
  exp_t sb[$];
  exp_t m;
  int   c = 0, checks = 0, errors = 0;
  bit   started = 1'b0;

  seg_scan_driver #(
    .NUM_DIGITS(N), .CLK_DIV(CD), .BLANK_CYCLES(BL),
    .SEG_ACTIVE_LOW(SAL), .DIG_ACTIVE_LOW(DAL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in),
    .blank_lz_in(blank_lz_in), .load(load), .pending(pending),
    .frame_done(frame_done), .seg_out(seg_out), .dig_out(dig_out)
  );

  always #5 clk = ~clk;

  // Index of the most recent load issued in a cycle strictly before lim, or -1.
  function automatic int find_before(input int lim);
    for (int i = loads.size() - 1; i >= 0; i--)
      if (loads[i].t < lim) return i;
    return -1;
  endfunction

  // Expected outputs after cc clock edges since reset release.
  function automatic exp_t expect_at(input int cc);
    exp_t e;
    ld_t  l;
    int   k, s, d, w;
    logic [7:0]  code;
    logic [15:0] above;
    e.seg = 8'h00; e.dig = 4'h0; e.pend = 1'b0; e.fd = 1'b0;
    if (cc > 0) begin
      s    = cc - 1;
      e.fd = (s % FL == FL - 1);
      k = find_before(cc);
      if (k >= 0) begin
        l = loads[k];
        w = l.t - (l.t % FL) + FL - 1;
        e.pend = (cc <= w) && (l.t != w);
      end
      if (s % CD >= BL) begin
        d = (s / CD) % N;
        l.t = 0; l.v = 16'h0; l.dp = 4'h0; l.blz = 1'b0;
        k = find_before((s / FL) * FL);
        if (k >= 0) l = loads[k];
        above = l.v >> (4 * d);
        code  = SEG_TAB[above[3:0]];
        if (l.blz && d > 0 && above == 16'h0) code = 8'h00;
        code[0] = l.dp[d];
        e.seg = code;
        e.dig = 4'(1 << d);
      end
    end
    e.seg = e.seg ^ {8{SAL}};
    e.dig = e.dig ^ {4{DAL}};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty at cycle %0d", c);
      end else begin
        m = sb.pop_front();
        chk("seg_out", seg_out, m.seg);
        chk("dig_out", {4'h0, dig_out}, {4'h0, m.dig});
        chk("pending", {7'h0, pending}, {7'h0, m.pend});
        chk("frame_done", {7'h0, frame_done}, {7'h0, m.fd});
      end
    end
  end

  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] dp, input logic blz);
    ld_t r;
    load = ld; value_in = v; dp_in = dp; blank_lz_in = blz;
    if (ld) begin
      r.t = c; r.v = v; r.dp = dp; r.blz = blz;
      loads.push_back(r);
    end
    @(posedge clk);
    c++;
    sb.push_back(expect_at(c));
    #1;
  endtask

  task automatic idle();
    step(1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
  endtask

  // Asynchronous reset asserted between edges; a load held during reset must be ignored.
  task automatic do_reset(input int n);
    sb.delete();
    loads.delete();
    c = 0;
    load = 1'b1; value_in = 16'h9999; dp_in = 4'hF; blank_lz_in = 1'b0;
    rst_n = 1'b0;
    repeat (n) begin
      sb.push_back(expect_at(0));
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    load  = 1'b0;
    sb.push_back(expect_at(0));
  endtask

  initial begin
    logic [15:0] rv;
    @(posedge clk);
    #1;
    started = 1'b1;
    do_reset(3);
    repeat (20) idle();
    step(1'b1, 16'h3FA9, 4'h0, 1'b0);
    repeat (40) idle();
    step(1'b1, 16'h1234, 4'h0, 1'b0);
    idle();
    step(1'b1, 16'h5678, 4'h0, 1'b0);
    repeat (40) idle();
    step(1'b1, 16'h0050, 4'b1000, 1'b1);
    repeat (40) idle();
    step(1'b1, 16'h0050, 4'b1000, 1'b0);
    repeat (40) idle();
    while (c % FL != FL - 1) idle();
    step(1'b1, 16'hABCD, 4'h0, 1'b0);
    repeat (40) idle();
    while (!((c / CD) % N == 2 && c % CD == 1)) idle();
    step(1'b1, 16'h9876, 4'h5, 1'b0);
    do_reset(2);
    repeat (40) idle();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        rv = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
        step(1'b1, rv, 4'($urandom), 1'($urandom));
      end else begin
        idle();
      end
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed N-digit seven-segment display driver with full hexadecimal decoding, per-digit decimal point, optional leading-zero blanking and anti-ghosting blank time. Sits between the result/status logic and the board's common-anode/cathode display pins. It replaces per-digit combinational decoding with one shared decoder, a scan prescaler and a double-buffered display value. New values are committed only at frame boundaries, so a frame is never torn.

## Interface
- NUM_DIGITS, 8, number of digits scanned (≥2); digit 0 = least significant
- CLK_DIV, 100000, clock cycles per digit slot (≥2)
- BLANK_CYCLES, 0, cycles at start of each slot with all digits off (0 ≤ BLANK_CYCLES < CLK_DIV)
- SEG_ACTIVE_LOW, 0, 1 inverts all seg_out bits
- DIG_ACTIVE_LOW, 1, 1 inverts all dig_out bits
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- value_in  in  4*NUM_DIGITS  nibble i = hex digit i
- dp_in  in  NUM_DIGITS  bit i lights decimal point of digit i
- blank_lz_in  in  1  enable leading-zero suppression for this value
- load  in  1  single-cycle strobe; captures value_in/dp_in/blank_lz_in
- pending  out  1  shadow buffer holds a value not yet displayed
- frame_done  out  1  one-cycle pulse when the last digit slot ends
- seg_out  out  8  {a,b,c,d,e,f,g,dp}, bit7 = a, bit0 = dp, polarity per SEG_ACTIVE_LOW
- dig_out  out  NUM_DIGITS  one-hot digit enable, polarity per DIG_ACTIVE_LOW

## Operation
- Segment code (active-high, before polarity):
  - 0 = 1111_1100, 1 = 0110_0000, 2 = 1101_1010, 3 = 1111_0010
  - 4 = 0110_0110, 5 = 1011_0110, 6 = 1011_1110, 7 = 1110_0000
  - 8 = 1111_1110, 9 = 1110_0110, A = 1110_1110, b = 0011_1110
  - C = 1001_1100, d = 0111_1010, E = 1001_1110, F = 1000_1110
  - Bit 0 is then replaced by the dp bit. Decode is total; no latches.
- Prescaler pcnt counts 0..CLK_DIV-1 and wraps. tick = (pcnt == CLK_DIV-1).
- Digit index idx advances on tick and wraps NUM_DIGITS-1 → 0. frame_done = tick && idx == NUM_DIGITS-1.
- Buffers: shadow and active, each holding value, dp and blank_lz.
  - load: shadow ← inputs, pending ← 1. A repeated load while pending overwrites shadow; latest wins.
  - Frame wrap (frame_done): active ← shadow if pending, then pending ← 0.
  - load coincident with frame wrap: the inputs go straight to active, shadow ← inputs, pending ← 0.
- Leading-zero blank: digit i > 0 is blanked when active.blank_lz = 1 and nibbles i..NUM_DIGITS-1 are all 0. Digit 0 is never blanked. A blanked digit still shows its dp bit.
- Output word for slot idx:
  - If pcnt < BLANK_CYCLES: all segments and all digits off.
  - Else: dig bit idx on, segments = code(active nibble idx), or dp only if the digit is blanked.

## Timing
- seg_out and dig_out are registered: they reflect the pcnt/idx/active state of the previous cycle, i.e. one-cycle latency.
- pending and frame_done are registered and update in the cycle after the triggering event.
- A value loaded at cycle t is first visible on the outputs in slot 0 of the frame following the next frame wrap.
- Reset (asynchronous, any time, including mid-frame):
  - pcnt = 0, idx = 0, shadow = active = 0, pending = 0, frame_done = 0.
  - seg_out and dig_out at the all-off level (SEG_ACTIVE_LOW ? 8'hFF : 8'h00; likewise for dig_out).
  - After release, the first slot is digit 0 and starts at pcnt = 0.
- load during reset is ignored.

## Test plan
Default configuration: NUM_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=1, polarities 0/1.
- Reset and scan: after reset with no load → seg_out = 8'h00 and dig_out = 4'hF. After the first blank cycle, the digit-0 slot shows seg_out = 8'hFC and dig_out = 4'hE. dig_out then steps E→D→B→7 every 4 cycles, and frame_done pulses every 16 cycles.
- Full hex: load value 0x3FA9 with dp_in = 0 → digits 0..3 show 8'hE6, 8'hEE, 8'h8E, 8'hF2 in successive slots of the next frame. Output is all-off for 1 cycle at the start of each slot.
- Double buffer: load 0x1234, then load 0x5678 two cycles later mid-frame → pending = 1 until frame_done. The rest of the current frame is unchanged, and the next frame shows 0x5678 only; 0x1234 never appears.
- Leading-zero blank: load 0x0050 with blank_lz_in = 1 and dp_in = 4'b1000 → digit 3 shows 8'h01 (dp only), digit 2 shows 8'h00, digit 1 shows 8'hB6, digit 0 shows 8'hFC. With blank_lz_in = 0, digit 2 shows 8'hFC.
- Coincident load and wrap: load 0xABCD in the frame_done cycle → pending stays 0, and the next frame displays 0xABCD.
- Mid-frame reset: assert rst_n = 0 during the digit-2 slot → outputs go all-off immediately without a clock edge, and pending = 0. After release, the display shows 0000 starting at digit 0.
